idu_issue_scoreboard: RTL
=========================

// Module: idu_issue_scoreboard
// PURPOSE
//  Issue controller between decode (IDU) and EXU. Holds one decoded instruction in an
//  issue register, tracks in-flight register writes per GPR, stalls RAW/WAW hazards,
//  serializes CSR/ecall/mret and handles flush. Writebacks arrive from ALU and MUL/DIV paths.
// PARAMETERS
//  PW      64  width of opaque decoded payload (imm, ALUOp, MemOp, ...) passed through
//  CNT_W   2   per-register pending-write counter width; max in-flight writes per rd = 2^CNT_W-1
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  dec_valid    in   1   decoded instruction valid
//  dec_ready    out  1   controller accepts decoded instruction this cycle
//  dec_rd/rs1/rs2 in 5   register indices
//  dec_use_rs1  in   1   instruction reads rs1;  dec_use_rs2 likewise for rs2
//  dec_wen      in   1   instruction writes rd
//  dec_serial   in   1   Ecall|Mret|Csrwen: must execute alone
//  dec_payload  in   PW  passed through unchanged
//  iss_valid    out  1   issue register occupied;  iss_ready in 1: EXU takes it
//  iss_rd 5 / iss_wen 1 / iss_serial 1 / iss_payload PW  out  registered copies
//  wb0_valid/wb0_rd  in 1/5  ALU-path writeback;  wb1_valid/wb1_rd  in 1/5  MUL/DIV writeback
//  serial_done  in   1   serialized instruction retired
//  flush        in   1   discard issue register contents (branch/trap redirect)
//  sb_empty     out  1   all counters zero and issue register empty
//  sb_err       out  1   sticky: writeback to a register whose counter is zero
//  stall_cnt    out  32  cycles with dec_valid && !dec_ready, saturating
// BEHAVIOUR
//  Reset: iss_valid=0, iss_* regs=0, all counters=0, state=RUN, sb_err=0, stall_cnt=0.
//  Accept: dec_valid && dec_ready -> instruction in issue register next cycle (latency 1).
//  Issue register loads when empty or when iss_valid && iss_ready same cycle; holds otherwise.
//  Counters: cnt[rd]++ on issue handshake (iss_valid&&iss_ready&&iss_wen&&iss_rd!=0);
//   cnt[r]-- per wbX_valid with wbX_rd==r!=0; wb0+wb1 to same r same cycle -> -2;
//   inc and dec same reg same cycle -> net; x0 never counted, never busy.
//  Hazard (uses registered state, no same-cycle wb bypass; clears the cycle after wb):
//   RAW: use_rsN && rsN!=0 && (cnt[rsN]!=0 || (iss_valid&&iss_wen&&iss_rd==rsN)).
//   WAW limit: dec_wen && cnt[dec_rd] == max (counting iss occupant) -> stall.
//  dec_ready = !flush && state==RUN && no hazard && (!iss_valid || iss_ready)
//   && (!dec_serial || sb_empty).
//  FSM: RUN: dec_valid&&dec_serial&&!sb_empty -> DRAIN; accept of serial instr -> SERIAL.
//   DRAIN: dec_ready=0 except when sb_empty: accepting serial -> SERIAL; dec_valid
//   dropped -> RUN. SERIAL: dec_ready=0; serial_done -> RUN.
//  Flush: iss_valid<=0 next cycle, dec_ready=0 that cycle, counters untouched (already-issued
//   ops still write back). DRAIN->RUN. SERIAL with serial instr still un-issued -> RUN;
//   already issued -> stay SERIAL. Flush beats simultaneous accept; issue handshake in the
//   flush cycle still counts.
//  Underflow: wb to zero counter -> counter stays 0, sb_err<=1 until reset.
//  stall_cnt holds at 32'hFFFF_FFFF. Reset mid-operation drops everything immediately.
// TESTING
//  1 add x5<-x1,x2 issued; next dec reads x5 -> dec_ready=0 until cycle after wb0_rd=5.
//  2 dec rd=0, then dec rs1=0 -> no stall; cnt never changes; sb_empty stays 1.
//  3 three issued writes to x7 (cnt=3), 4th write to x7 -> stall; one wb1_rd=7 -> accepted.
//  4 csrrw with cnt[x3]=1 -> DRAIN, stall until wb; accepted; next instr stalls until serial_done.
//  5 flush while iss_valid=1 && iss_ready=0 -> iss_valid=0 next cycle, cnt unchanged.
//  6 wb0 and wb1 both rd=9 with cnt=2 -> 0; extra wb rd=9 -> sb_err=1, cnt stays 0.

Source files
------------

// File: rtl/idu_issue_scoreboard.sv
// Decode-to-execute issue stage: single issue register, per-GPR in-flight
// write counters, RAW/WAW stalls, serialization of CSR/ecall/mret, flush.
module idu_issue_scoreboard #(
  parameter int PW    = 64,
  parameter int CNT_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec_valid,
  output logic          dec_ready,
  input  logic [4:0]    dec_rd,
  input  logic [4:0]    dec_rs1,
  input  logic [4:0]    dec_rs2,
  input  logic          dec_use_rs1,
  input  logic          dec_use_rs2,
  input  logic          dec_wen,
  input  logic          dec_serial,
  input  logic [PW-1:0] dec_payload,
  output logic          iss_valid,
  input  logic          iss_ready,
  output logic [4:0]    iss_rd,
  output logic          iss_wen,
  output logic          iss_serial,
  output logic [PW-1:0] iss_payload,
  input  logic          wb0_valid,
  input  logic [4:0]    wb0_rd,
  input  logic          wb1_valid,
  input  logic [4:0]    wb1_rd,
  input  logic          serial_done,
  input  logic          flush,
  output logic          sb_empty,
  output logic          sb_err,
  output logic [31:0]   stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SERIAL = 2'd2
  } state_t;

  state_t state;

  logic [CNT_W-1:0] cnt     [32];
  logic [CNT_W-1:0] cnt_nxt [32];
  logic [CNT_W:0]   cur;
  logic [CNT_W:0]   dsum;
  logic [CNT_W:0]   isum;
  logic [CNT_W:0]   rd_load;
  logic             under;
  logic             any_pend;
  logic             occ_w;
  logic             iss_hs;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             waw;
  logic             allow;
  logic             accept;

  assign iss_hs = iss_valid && iss_ready;
  assign occ_w  = iss_valid && iss_wen && (iss_rd != 5'd0);

  always_comb begin
    any_pend = 1'b0;
    for (int r = 1; r < 32; r++)
      any_pend = any_pend | (cnt[r] != '0);
  end

  assign sb_empty = !any_pend && !iss_valid;

  // The issue-register occupant counts as one more in-flight write.
  assign rs1_busy = dec_use_rs1 && (dec_rs1 != 5'd0) &&
    ((cnt[dec_rs1] != '0) || (occ_w && iss_rd == dec_rs1));
  assign rs2_busy = dec_use_rs2 && (dec_rs2 != 5'd0) &&
    ((cnt[dec_rs2] != '0) || (occ_w && iss_rd == dec_rs2));

  assign rd_load = {1'b0, cnt[dec_rd]} +
    (CNT_W+1)'(occ_w && iss_rd == dec_rd);
  assign waw = dec_wen && (dec_rd != 5'd0) &&
    (rd_load >= {1'b0, {CNT_W{1'b1}}});

  assign allow = (state == RUN) ||
    (state == DRAIN && sb_empty && dec_serial);

  assign dec_ready = !flush && allow &&
    !rs1_busy && !rs2_busy && !waw &&
    (!iss_valid || iss_ready) &&
    (!dec_serial || sb_empty);

  assign accept = dec_valid && dec_ready;

  always_comb begin
    under = 1'b0;
    cur   = '0;
    dsum  = '0;
    isum  = '0;
    for (int r = 0; r < 32; r++) begin
      cur  = {1'b0, cnt[r]};
      dsum = (CNT_W+1)'(wb0_valid && wb0_rd == 5'(r)) +
             (CNT_W+1)'(wb1_valid && wb1_rd == 5'(r));
      isum = (CNT_W+1)'(iss_hs && iss_wen && iss_rd == 5'(r));
      cnt_nxt[r] = '0;
      if (r != 0) begin
        if (dsum > cur) begin
          under      = 1'b1;
          cnt_nxt[r] = isum[CNT_W-1:0];
        end else begin
          cnt_nxt[r] = CNT_W'(cur - dsum + isum);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++)
        cnt[r] <= '0;
      sb_err    <= 1'b0;
      stall_cnt <= 32'd0;
    end else begin
      for (int r = 0; r < 32; r++)
        cnt[r] <= cnt_nxt[r];
      if (under)
        sb_err <= 1'b1;
      if (dec_valid && !dec_ready && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid   <= 1'b0;
      iss_rd      <= 5'd0;
      iss_wen     <= 1'b0;
      iss_serial  <= 1'b0;
      iss_payload <= '0;
    end else if (flush) begin
      iss_valid <= 1'b0;
    end else if (accept) begin
      iss_valid   <= 1'b1;
      iss_rd      <= dec_rd;
      iss_wen     <= dec_wen;
      iss_serial  <= dec_serial;
      iss_payload <= dec_payload;
    end else if (iss_hs) begin
      iss_valid <= 1'b0;
    end
  end

  // A flushed serial op that never left the issue register releases SERIAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (accept && dec_serial)
            state <= SERIAL;
          else if (!flush && dec_valid && dec_serial && !sb_empty)
            state <= DRAIN;
        end
        DRAIN: begin
          if (flush)
            state <= RUN;
          else if (accept)
            state <= SERIAL;
          else if (!dec_valid)
            state <= RUN;
        end
        SERIAL: begin
          if (serial_done)
            state <= RUN;
          else if (flush && iss_valid && iss_serial && !iss_ready)
            state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
